// File: rtl/reg_snapshot_reader_if.sv
// Address/data beat stream from the snapshot reader to its sink.
// Master drives the beat, slave answers with OutReady.
interface reg_snapshot_reader_if #(
    parameter int W = 8,
    parameter int D = 4
);
    logic         OutValid;
    logic         OutReady;
    logic [W-1:0] OutData;
    logic [D-1:0] OutAddr;

    modport master (
        output OutValid,
        output OutData,
        output OutAddr,
        input  OutReady
    );

    modport slave (
        input  OutValid,
        input  OutData,
        input  OutAddr,
        output OutReady
    );
endinterface

// File: rtl/reg_snapshot_reader.sv
// Walks a register range through the register file read port and streams
// each captured value as an address/data beat; waits out same-register writes.
module reg_snapshot_reader #(
    parameter int W = 8,
    parameter int D = 4
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   Start,
    input  logic [D-1:0]           FirstAddr,
    input  logic [D-1:0]           LastAddr,
    input  logic                   Abort,
    output logic [D-1:0]           RdAddr,
    input  logic [W-1:0]           RdData,
    input  logic                   WrEn,
    input  logic [D-1:0]           WrAddr,
    reg_snapshot_reader_if.master  snap,
    output logic                   Busy,
    output logic                   Done
);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        SEND,
        DONE
    } state_t;

    state_t       state;
    logic [D-1:0] last_addr;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [D-1:0] out_addr;
    logic         hazard;

    assign hazard = WrEn && (WrAddr == RdAddr);

    assign snap.OutValid = out_valid;
    assign snap.OutData  = out_data;
    assign snap.OutAddr  = out_addr;

    assign Busy = (state == CAPTURE) || (state == SEND);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            last_addr <= '0;
            RdAddr    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            Done      <= 1'b0;
        end else if (Abort && state != IDLE) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            Done      <= 1'b0;
        end else begin
            Done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (Start) begin
                        last_addr <= LastAddr;
                        RdAddr    <= FirstAddr;
                        state     <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    // A same-cycle write lands at this edge; retry to see it.
                    if (!hazard) begin
                        out_data  <= RdData;
                        out_addr  <= RdAddr;
                        out_valid <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (out_valid && snap.OutReady) begin
                        out_valid <= 1'b0;
                        if (RdAddr == last_addr) begin
                            state <= DONE;
                            Done  <= 1'b1;
                        end else begin
                            RdAddr <= RdAddr + 1'b1;
                            state  <= CAPTURE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_snapshot_reader.sv
// Bench for reg_snapshot_reader: register file model, directed cases and
// random scans checked against an address-list/value model.
module tb_reg_snapshot_reader;

    localparam int W = 8;
    localparam int D = 4;
    localparam int N = 1 << D;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         Start;
    logic [D-1:0] FirstAddr;
    logic [D-1:0] LastAddr;
    logic         Abort;
    logic [D-1:0] RdAddr;
    logic [W-1:0] RdData;
    logic         WrEn;
    logic [D-1:0] WrAddr;
    logic [W-1:0] WrData;
    logic         Busy;
    logic         Done;

    logic [W-1:0] regs [N];

    int n_chk = 0;
    int n_pass = 0;

    reg_snapshot_reader_if #(.W(W), .D(D)) sif ();

    reg_snapshot_reader #(.W(W), .D(D)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .FirstAddr (FirstAddr),
        .LastAddr  (LastAddr),
        .Abort     (Abort),
        .RdAddr    (RdAddr),
        .RdData    (RdData),
        .WrEn      (WrEn),
        .WrAddr    (WrAddr),
        .snap      (sif),
        .Busy      (Busy),
        .Done      (Done)
    );

    always #5 Clk = ~Clk;

    always_ff @(posedge Clk) begin
        if (WrEn) regs[WrAddr] <= WrData;
    end

    assign RdData = regs[RdAddr];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic wr(input int a, input int d);
        WrEn   = 1'b1;
        WrAddr = a[D-1:0];
        WrData = d[W-1:0];
        @(negedge Clk);
        WrEn = 1'b0;
    endtask

    // Runs one scan; the model is the list of addresses the range implies,
    // each beat carrying the register value current when it appears.
    task automatic scan(input int first, input int last, input int rdy_pct,
                        input int wr_pct, input int stall_beat,
                        input int abort_beat, input bit timed);
        int n, acc, seen, cyc, stall;
        bit fin, pv, hs_prev;
        logic [W-1:0] pd;
        logic [D-1:0] pa;
        logic [D-1:0] fa;
        logic [D-1:0] exp_a [$];
        n = ((last - first) & (N - 1)) + 1;
        for (int i = 0; i < n; i++) begin
            fa = D'((first + i) % N);
            exp_a.push_back(fa);
        end
        fa = D'(first);
        Start = 1'b1;
        FirstAddr = D'(first);
        LastAddr = D'(last);
        @(negedge Clk);
        Start = 1'b0;
        cyc = 1; acc = 0; seen = 0; stall = 0;
        fin = 0; pv = 0; hs_prev = 0; pd = '0; pa = '0;
        check("capture_entry", {Busy, sif.OutValid, RdAddr}, {1'b1, 1'b0, fa});
        while (!fin && cyc < 800) begin
            if (Done) begin
                check("done_count", acc, n);
                check("done_after_last", hs_prev, 1);
                check("done_busy", Busy, 0);
                if (timed) check("done_cycle", cyc, 2 * n + 1);
                fin = 1;
            end else begin
                if (sif.OutValid && !pv) begin
                    if (seen < n) check("beat_addr", sif.OutAddr, exp_a[seen]);
                    else check("extra_beat", seen, n - 1);
                    check("beat_data", sif.OutData, regs[sif.OutAddr]);
                    check("beat_busy", Busy, 1);
                    if (timed) check("beat_cycle", cyc, 2 + 2 * seen);
                    seen++;
                end
                if (sif.OutValid && pv)
                    check("stall_hold", {sif.OutData, sif.OutAddr}, {pd, pa});
                if (abort_beat >= 0 && acc == abort_beat && !sif.OutValid) begin
                    sif.OutReady = 1'b0;
                    WrEn = 1'b0;
                    Abort = 1'b1;
                    Start = 1'b1;
                    FirstAddr = '0;
                    LastAddr = '0;
                    @(negedge Clk);
                    Abort = 1'b0;
                    Start = 1'b0;
                    check("abort_idle", {sif.OutValid, Busy, Done}, 3'b000);
                    @(negedge Clk);
                    check("abort_start_ignored", {Busy, Done}, 2'b00);
                    return;
                end
                if (sif.OutValid && seen - 1 == stall_beat && stall < 5) begin
                    sif.OutReady = 1'b0;
                    stall++;
                end else begin
                    sif.OutReady = ($urandom_range(99) < rdy_pct);
                end
                hs_prev = sif.OutValid && sif.OutReady;
                if (hs_prev) acc++;
                if ($urandom_range(99) < wr_pct) begin
                    WrEn = 1'b1;
                    WrAddr = $urandom_range(1) ? RdAddr : D'($urandom_range(N - 1));
                    WrData = W'($urandom);
                end else begin
                    WrEn = 1'b0;
                end
                pv = sif.OutValid;
                pd = sif.OutData;
                pa = sif.OutAddr;
                @(negedge Clk);
                cyc++;
            end
        end
        if (!fin) check("scan_timeout", 0, 1);
        if (stall_beat >= 0) check("stall_cycles", stall, 5);
        sif.OutReady = 1'b0;
        WrEn = 1'b0;
        @(negedge Clk);
        check("done_single", {Done, Busy}, 2'b00);
    endtask

    initial begin
        int f, l, t;
        Reset = 1'b1;
        Start = 1'b0;
        Abort = 1'b0;
        FirstAddr = '0;
        LastAddr = '0;
        WrEn = 1'b0;
        WrAddr = '0;
        WrData = '0;
        sif.OutReady = 1'b0;
        @(negedge Clk);
        for (int i = 0; i < N; i++) wr(i, $urandom_range(255));
        check("rst_valid", sif.OutValid, 0);
        check("rst_busy_done", {Busy, Done}, 2'b00);
        check("rst_addr", RdAddr, 0);
        check("rst_out", {sif.OutData, sif.OutAddr}, 0);
        Reset = 1'b0;
        @(negedge Clk);

        wr(3, 8'h11);
        wr(4, 8'h22);
        wr(5, 8'h33);
        scan(3, 5, 100, 0, -1, -1, 1);
        scan(14, 1, 100, 0, -1, -1, 1);
        scan(0, 15, 100, 0, -1, -1, 1);
        scan(7, 7, 100, 0, -1, -1, 1);
        scan(5, 4, 100, 0, -1, -1, 1);
        scan(2, 6, 100, 0, 1, -1, 0);
        scan(2, 7, 100, 0, -1, 2, 0);

        wr(4, 8'h5A);
        Start = 1'b1;
        FirstAddr = 4'd4;
        LastAddr = 4'd4;
        @(negedge Clk);
        Start = 1'b0;
        check("hz_rdaddr", RdAddr, 4);
        WrEn = 1'b1;
        WrAddr = 4'd4;
        WrData = 8'hA5;
        sif.OutReady = 1'b1;
        @(negedge Clk);
        WrEn = 1'b0;
        check("hz_delay", sif.OutValid, 0);
        @(negedge Clk);
        check("hz_beat", {sif.OutValid, sif.OutAddr, sif.OutData}, {1'b1, 4'd4, 8'hA5});
        @(negedge Clk);
        check("hz_done", Done, 1);
        sif.OutReady = 1'b0;
        @(negedge Clk);
        check("hz_done_once", Done, 0);

        Start = 1'b1;
        FirstAddr = 4'd9;
        LastAddr = 4'd8;
        @(negedge Clk);
        Start = 1'b0;
        t = 0;
        while (!sif.OutValid && t < 20) begin
            @(negedge Clk);
            t++;
        end
        check("rst_mid_reach_send", sif.OutValid, 1);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check("rst_mid_state", {sif.OutValid, Busy, Done, RdAddr}, 0);
        check("rst_mid_out", {sif.OutData, sif.OutAddr}, 0);
        scan(10, 12, 100, 0, -1, -1, 1);

        for (int r = 0; r < 12; r++) begin
            f = $urandom_range(N - 1);
            l = $urandom_range(N - 1);
            scan(f, l, $urandom_range(100, 30), $urandom_range(40), -1, -1, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
